// File: rtl/fifo_ctrl_v2.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through reads,
// fill level, programmable almost-full/almost-empty thresholds and sticky error flags.
module fifo_ctrl_v2 #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter bit FWFT       = 1'b0,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         wren,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         rden,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_ctrl_v2: DEPTH must be >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_ctrl_v2: AF_LEVEL must be <= DEPTH");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
    $error("fifo_ctrl_v2: AE_LEVEL must be < AF_LEVEL");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  rd_ok, wr_ok, mem_we;

  // Handshake: wren/rden are single-cycle requests sampled at the rising edge;
  // a request is accepted (wr_ok/rd_ok) without back-pressure, a rejected one
  // only sets the sticky error flag. A read frees the slot for a same-cycle write.
  assign rd_ok  = rden & ~empty;
  assign wr_ok  = wren & (~full | rd_ok);
  assign mem_we = wr_ok & ~clr;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    data_d      = data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      data_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      if (rd_ok) begin
        rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
        data_d = mem_q[rptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q | (wren & ~wr_ok);
      underflow_d = underflow_q | (rden & empty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q] <= i_data;
  end

  // In FWFT mode data_q holds the last popped head, giving a stable value when empty.
  if (FWFT) begin : g_fwft
    assign o_data = empty ? data_q : mem_q[rptr_q];
  end else begin : g_std
    assign o_data = data_q;
  end

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_v2.sv
// Directed bench for fifo_ctrl_v2: three instances (DEPTH=6 standard, DEPTH=6 FWFT,
// DEPTH=8 with AF=6/AE=2) share one stimulus stream; each phase starts from a clear.
module tb_fifo_ctrl_v2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic [7:0] i_data = 8'h00;

  logic [7:0] a_o_data, b_o_data, c_o_data;
  logic       a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic       b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic       c_full, c_empty, c_af, c_ae, c_ov, c_un;
  logic [2:0] a_count, b_count;
  logic [3:0] c_count;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  fifo_ctrl_v2 #(.DEPTH(6), .DATA_WIDTH(8), .FWFT(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .i_data(i_data), .rden(rden),
    .o_data(a_o_data), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_count), .overflow(a_ov), .underflow(a_un));

  fifo_ctrl_v2 #(.DEPTH(6), .DATA_WIDTH(8), .FWFT(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .i_data(i_data), .rden(rden),
    .o_data(b_o_data), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_count), .overflow(b_ov), .underflow(b_un));

  fifo_ctrl_v2 #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(1'b0), .AF_LEVEL(6), .AE_LEVEL(2)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .i_data(i_data), .rden(rden),
    .o_data(c_o_data), .full(c_full), .empty(c_empty), .almost_full(c_af),
    .almost_empty(c_ae), .count(c_count), .overflow(c_ov), .underflow(c_un));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; wren = 1'b0; rden = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] v);
    wren = 1'b1; i_data = v;
    tick();
    wren = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_odata", 32'(a_o_data), 32'd0);
    chk("rst_ae", 32'(a_ae), 32'd1);
    chk("rst_af", 32'(c_af), 32'd0);
    chk("rst_ov_un", 32'({a_ov, a_un}), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: fill to full, overflow, drain in order
    for (int i = 1; i <= 6; i++) push(8'(i));
    chk("t1_full", 32'(a_full), 32'd1);
    chk("t1_count6", 32'(a_count), 32'd6);
    chk("t1_af", 32'(a_af), 32'd1);
    push(8'd7);
    chk("t1_overflow", 32'(a_ov), 32'd1);
    chk("t1_count_after_ovf", 32'(a_count), 32'd6);
    rden = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("t1_rd_data", 32'(a_o_data), 32'(i));
    end
    rden = 1'b0;
    chk("t1_empty", 32'(a_empty), 32'd1);
    chk("t1_no_underflow", 32'(a_un), 32'd0);
    rden = 1'b1;
    tick();
    rden = 1'b0;
    chk("t1_underflow", 32'(a_un), 32'd1);
    chk("t1_odata_hold", 32'(a_o_data), 32'd6);

    // clr clears sticky flags and o_data
    do_clr();
    chk("clr_ov", 32'(a_ov), 32'd0);
    chk("clr_un", 32'(a_un), 32'd0);
    chk("clr_count", 32'(a_count), 32'd0);
    chk("clr_odata", 32'(a_o_data), 32'd0);

    // 2: steady-state simultaneous traffic wraps both pointers repeatedly
    exp_q.delete();
    push(8'h40); exp_q.push_back(8'h40);
    push(8'h41); exp_q.push_back(8'h41);
    for (int k = 0; k < 20; k++) begin
      wren = 1'b1; rden = 1'b1; i_data = 8'(8'h50 + k);
      tick();
      exp_v = exp_q.pop_front();
      exp_q.push_back(8'(8'h50 + k));
      chk("t2_wrap_data", 32'(a_o_data), 32'(exp_v));
      chk("t2_count", 32'(a_count), 32'd2);
    end
    wren = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_v = exp_q.pop_front();
      chk("t2_drain", 32'(a_o_data), 32'(exp_v));
    end
    rden = 1'b0;
    chk("t2_empty", 32'(a_empty), 32'd1);

    // 3: full plus simultaneous read and write
    do_clr();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      push(8'(8'h60 + i));
      exp_q.push_back(8'(8'h60 + i));
    end
    chk("t3_full", 32'(a_full), 32'd1);
    wren = 1'b1; rden = 1'b1; i_data = 8'h66;
    tick();
    wren = 1'b0; rden = 1'b0;
    exp_v = exp_q.pop_front();
    exp_q.push_back(8'h66);
    chk("t3_count", 32'(a_count), 32'd6);
    chk("t3_no_ovf", 32'(a_ov), 32'd0);
    chk("t3_head", 32'(a_o_data), 32'(exp_v));
    rden = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      chk("t3_drain", 32'(a_o_data), 32'(exp_v));
    end
    rden = 1'b0;

    // 4: empty plus simultaneous read and write
    do_clr();
    wren = 1'b1; rden = 1'b1; i_data = 8'h77;
    tick();
    wren = 1'b0; rden = 1'b0;
    chk("t4_count", 32'(a_count), 32'd1);
    chk("t4_underflow", 32'(a_un), 32'd1);
    chk("t4_odata_hold", 32'(a_o_data), 32'd0);
    rden = 1'b1;
    tick();
    rden = 1'b0;
    chk("t4_read", 32'(a_o_data), 32'h77);
    chk("t4_empty", 32'(a_empty), 32'd1);

    // 5: first-word-fall-through
    do_clr();
    chk("t5_clr_odata", 32'(b_o_data), 32'd0);
    push(8'hA5);
    chk("t5_not_empty", 32'(b_empty), 32'd0);
    chk("t5_fwft_head", 32'(b_o_data), 32'hA5);
    tick();
    chk("t5_head_stable", 32'(b_o_data), 32'hA5);
    push(8'hB6);
    chk("t5_head_kept", 32'(b_o_data), 32'hA5);
    chk("t5_count2", 32'(b_count), 32'd2);
    rden = 1'b1;
    tick();
    chk("t5_next_head", 32'(b_o_data), 32'hB6);
    chk("t5_count1", 32'(b_count), 32'd1);
    tick();
    rden = 1'b0;
    chk("t5_empty", 32'(b_empty), 32'd1);
    chk("t5_last_head", 32'(b_o_data), 32'hB6);

    // 6: programmable thresholds on DEPTH=8, AF=6, AE=2
    do_clr();
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      chk("t6_count", 32'(c_count), 32'(i));
      chk("t6_ae", 32'(c_ae), (i <= 2) ? 32'd1 : 32'd0);
      chk("t6_af", 32'(c_af), (i >= 6) ? 32'd1 : 32'd0);
    end
    chk("t6_full", 32'(c_full), 32'd1);
    do_clr();
    for (int i = 1; i <= 4; i++) push(8'(i));
    chk("t6_mid_count", 32'(c_count), 32'd4);
    clr = 1'b1; wren = 1'b1; i_data = 8'hEE;
    tick();
    clr = 1'b0; wren = 1'b0;
    chk("t6_clr_count", 32'(c_count), 32'd0);
    chk("t6_clr_ae", 32'(c_ae), 32'd1);
    chk("t6_clr_af", 32'(c_af), 32'd0);
    chk("t6_clr_ov", 32'(c_ov), 32'd0);

    // Asynchronous reset mid-operation
    for (int i = 1; i <= 3; i++) push(8'(i));
    chk("ar_pre_count", 32'(c_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(c_count), 32'd0);
    chk("ar_empty", 32'(c_empty), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("ar_still_empty", 32'(c_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
